// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command-bus sequencer: owns the refresh timer and grants the shared
// command/address bus to the refresh, write-burst or read-burst engine.
module sdram_cmd_arbiter #(
  parameter int REF_PERIOD = 780,
  parameter int REF_CNT_W  = 10
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Init_done,
  input  logic       Wr_req,
  input  logic       Rd_req,
  input  logic       Aref_done,
  input  logic       Wr_done,
  input  logic       Rd_done,
  output logic       Aref_en,
  output logic       Wr_en,
  output logic       Rd_en,
  output logic [1:0] Cmd_sel,
  output logic       Busy,
  output logic       Ref_err
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  localparam logic [REF_CNT_W-1:0] CNT_LAST = REF_CNT_W'(REF_PERIOD - 1);

  logic [2:0]           state_q, state_d;
  logic [REF_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ref_req_q, ref_req_d;
  logic                 ref_err_q, ref_err_d;
  logic                 last_wr_q, last_wr_d;
  logic                 aref_en_q, aref_en_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic [1:0]           cmd_sel_q, cmd_sel_d;
  logic                 busy_q, busy_d;
  logic                 wrap;

  assign wrap = (state_q != ST_INIT) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_req_d = ref_req_q;
    ref_err_d = ref_err_q;
    last_wr_d = last_wr_q;
    aref_en_d = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;

    if (!Init_done) begin
      // Losing init abandons everything except the sticky refresh error.
      state_d   = ST_INIT;
      cnt_d     = '0;
      ref_req_d = 1'b0;
    end else begin
      if (state_q != ST_INIT) begin
        cnt_d = wrap ? '0 : cnt_q + REF_CNT_W'(1);
        if (wrap) begin
          ref_req_d = 1'b1;
          if (ref_req_q) ref_err_d = 1'b1;
        end
      end

      case (state_q)
        ST_INIT: state_d = ST_IDLE;
        ST_IDLE: begin
          if (ref_req_q) begin
            state_d   = ST_AREF;
            aref_en_d = 1'b1;
            ref_req_d = wrap;
          end else if (Wr_req && (!Rd_req || !last_wr_q)) begin
            state_d   = ST_WRITE;
            wr_en_d   = 1'b1;
            last_wr_d = 1'b1;
          end else if (Rd_req) begin
            state_d   = ST_READ;
            rd_en_d   = 1'b1;
            last_wr_d = 1'b0;
          end
        end
        ST_AREF:  if (Aref_done) state_d = ST_IDLE;
        ST_WRITE: if (Wr_done)   state_d = ST_IDLE;
        ST_READ:  if (Rd_done)   state_d = ST_IDLE;
        default:  state_d = ST_INIT;
      endcase
    end

    case (state_d)
      ST_AREF:  cmd_sel_d = 2'd1;
      ST_WRITE: cmd_sel_d = 2'd2;
      ST_READ:  cmd_sel_d = 2'd3;
      default:  cmd_sel_d = 2'd0;
    endcase
    busy_d = (state_d == ST_AREF) || (state_d == ST_WRITE) || (state_d == ST_READ);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      ref_req_q <= 1'b0;
      ref_err_q <= 1'b0;
      last_wr_q <= 1'b0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cmd_sel_q <= 2'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_req_q <= ref_req_d;
      ref_err_q <= ref_err_d;
      last_wr_q <= last_wr_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cmd_sel_q <= cmd_sel_d;
      busy_q    <= busy_d;
    end
  end

  assign Aref_en = aref_en_q;
  assign Wr_en   = wr_en_q;
  assign Rd_en   = rd_en_q;
  assign Cmd_sel = cmd_sel_q;
  assign Busy    = busy_q;
  assign Ref_err = ref_err_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter with a 100-cycle refresh interval.
// tk counts rising edges since Init_done first rose; tk=1 is the first IDLE cycle,
// so timer wraps land on edges tk=101,201,301,...
module tb_sdram_cmd_arbiter;

  logic       Clk, Rst, Init_done, Wr_req, Rd_req, Aref_done, Wr_done, Rd_done;
  logic       Aref_en, Wr_en, Rd_en, Busy, Ref_err;
  logic [1:0] Cmd_sel;

  int n_chk = 0;
  int n_pass = 0;
  int tk = 0;
  int stray = 0;

  sdram_cmd_arbiter #(.REF_PERIOD(100), .REF_CNT_W(7)) dut (
    .Clk(Clk), .Rst(Rst), .Init_done(Init_done), .Wr_req(Wr_req), .Rd_req(Rd_req),
    .Aref_done(Aref_done), .Wr_done(Wr_done), .Rd_done(Rd_done),
    .Aref_en(Aref_en), .Wr_en(Wr_en), .Rd_en(Rd_en), .Cmd_sel(Cmd_sel),
    .Busy(Busy), .Ref_err(Ref_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
    tk++;
  endtask

  // Idle-gap filler: any grant pulse seen here is unexpected.
  task automatic run_to(input int t);
    while (tk < t) begin
      tick();
      if (Aref_en || Wr_en || Rd_en) stray++;
    end
  endtask

  task automatic test_reset();
    int bad;
    int at;
    Rst = 1'b1; Init_done = 1'b0; Wr_req = 1'b0; Rd_req = 1'b0;
    Aref_done = 1'b0; Wr_done = 1'b0; Rd_done = 1'b0;
    #100;
    n_chk++;
    if ({Aref_en, Wr_en, Rd_en, Cmd_sel, Busy, Ref_err} !== 7'd0)
      $display("FAIL reset_outputs: got %b want 0000000", {Aref_en, Wr_en, Rd_en, Cmd_sel, Busy, Ref_err});
    else n_pass++;
    #100;
    Rst = 1'b0;
    bad = 0;
    while ($time < 500) begin
      tick();
      if (Cmd_sel !== 2'd0 || Aref_en || Wr_en || Rd_en || Busy) bad++;
    end
    n_chk++;
    if (bad !== 0) $display("FAIL init_quiet: got %0d active cycles want 0", bad);
    else n_pass++;
    Init_done = 1'b1;
    tk = 0;
    tick();
    n_chk++;
    if (Cmd_sel !== 2'd0 || Aref_en || Wr_en || Rd_en)
      $display("FAIL idle_entry: got cmd_sel=%0d en=%b want 0/000", Cmd_sel, {Aref_en, Wr_en, Rd_en});
    else n_pass++;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (Aref_en) begin at = tk; break; end
    end
    // Wrap on edge 101 registers ref_req; IDLE grants AREF on the following edge.
    n_chk++;
    if (at !== 102) $display("FAIL first_aref: got tk=%0d want 102", at);
    else n_pass++;
    n_chk++;
    if (Cmd_sel !== 2'd1 || Busy !== 1'b1)
      $display("FAIL aref_bus: got cmd_sel=%0d busy=%b want 1/1", Cmd_sel, Busy);
    else n_pass++;
    Aref_done = 1'b1;
    tick();
    Aref_done = 1'b0;
    n_chk++;
    if (Cmd_sel !== 2'd0 || Busy !== 1'b0 || Aref_en !== 1'b0)
      $display("FAIL aref_done_same_cycle: got cmd_sel=%0d busy=%b want 0/0", Cmd_sel, Busy);
    else n_pass++;
  endtask

  task automatic test_write();
    int n2, nb, nen;
    logic first_en;
    Wr_req = 1'b1;
    tick();
    Wr_req = 1'b0;
    n2 = 0; nb = 0; nen = 0; first_en = Wr_en;
    for (int i = 0; i < 9; i++) begin
      if (Cmd_sel == 2'd2) n2++;
      if (Busy) nb++;
      if (Wr_en) nen++;
      if (i == 8) Wr_done = 1'b1;
      tick();
    end
    Wr_done = 1'b0;
    n_chk++;
    if (first_en !== 1'b1) $display("FAIL wr_en_latency: got %b want 1", first_en);
    else n_pass++;
    n_chk++;
    if (n2 !== 9 || nb !== 9 || nen !== 1)
      $display("FAIL write_burst: got sel2=%0d busy=%0d en=%0d want 9/9/1", n2, nb, nen);
    else n_pass++;
    n_chk++;
    if (Cmd_sel !== 2'd0 || Busy !== 1'b0)
      $display("FAIL write_return: got cmd_sel=%0d busy=%b want 0/0", Cmd_sel, Busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] grants;
    int ng, wide;
    logic prev_en;
    grants = '0; ng = 0; wide = 0; prev_en = 1'b0;
    Wr_req = 1'b1; Rd_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      Wr_done = 1'b0; Rd_done = 1'b0;
      if (prev_en && (Wr_en || Rd_en)) wide++;
      if (Wr_en || Rd_en) begin
        if (ng < 4) grants[3-ng] = Wr_en;
        ng++;
        if (ng == 4) begin Wr_req = 1'b0; Rd_req = 1'b0; end
      end else if (prev_en) begin
        if (Cmd_sel == 2'd2) Wr_done = 1'b1;
        if (Cmd_sel == 2'd3) Rd_done = 1'b1;
      end
      prev_en = Wr_en || Rd_en;
      if (ng >= 4 && Cmd_sel == 2'd0) break;
    end
    // Last grant before this was a write, so the first tie goes to read.
    n_chk++;
    if (grants !== 4'b0101 || ng !== 4)
      $display("FAIL rr_order: got %b (n=%0d) want 0101 (R,W,R,W) n=4", grants, ng);
    else n_pass++;
    n_chk++;
    if (wide !== 0) $display("FAIL en_width: got %0d wide pulses want 0", wide);
    else n_pass++;
  endtask

  task automatic test_refresh_after_read();
    int n3;
    run_to(185);
    Rd_req = 1'b1;
    tick();
    Rd_req = 1'b0;
    n_chk++;
    if (Rd_en !== 1'b1) $display("FAIL rd_grant: got %b want 1", Rd_en);
    else n_pass++;
    n3 = 0;
    for (int i = 0; i < 20; i++) begin
      if (Cmd_sel == 2'd3) n3++;
      if (tk == 195) Wr_req = 1'b1;
      if (i == 19) Rd_done = 1'b1;
      tick();
    end
    Rd_done = 1'b0;
    n_chk++;
    if (n3 !== 20) $display("FAIL read_len: got %0d want 20", n3);
    else n_pass++;
    n_chk++;
    if (Cmd_sel !== 2'd0 || Aref_en || Wr_en)
      $display("FAIL post_read_idle: got cmd_sel=%0d aref=%b wr=%b want 0/0/0", Cmd_sel, Aref_en, Wr_en);
    else n_pass++;
    tick();
    n_chk++;
    if (Aref_en !== 1'b1 || Wr_en !== 1'b0 || Cmd_sel !== 2'd1)
      $display("FAIL aref_priority: got aref=%b wr=%b sel=%0d want 1/0/1", Aref_en, Wr_en, Cmd_sel);
    else n_pass++;
    Wr_done = 1'b1;
    tick();
    Wr_done = 1'b0;
    n_chk++;
    if (Cmd_sel !== 2'd1) $display("FAIL foreign_done: got sel=%0d want 1", Cmd_sel);
    else n_pass++;
    tick();
    Aref_done = 1'b1;
    tick();
    Aref_done = 1'b0;
    tick();
    n_chk++;
    if (Wr_en !== 1'b1 || Cmd_sel !== 2'd2)
      $display("FAIL pending_write: got wr=%b sel=%0d want 1/2", Wr_en, Cmd_sel);
    else n_pass++;
    Wr_req = 1'b0;
    Wr_done = 1'b1;
    tick();
    Wr_done = 1'b0;
  endtask

  task automatic test_wrap_vs_grant();
    run_to(300);
    Wr_req = 1'b1;
    tick();
    Wr_req = 1'b0;
    n_chk++;
    if (Wr_en !== 1'b1 || Aref_en !== 1'b0)
      $display("FAIL wrap_grant: got wr=%b aref=%b want 1/0", Wr_en, Aref_en);
    else n_pass++;
    tick();
    tick();
    Wr_done = 1'b1;
    tick();
    Wr_done = 1'b0;
    tick();
    n_chk++;
    if (Aref_en !== 1'b1 || tk !== 305)
      $display("FAIL deferred_aref: got aref=%b at tk=%0d want 1 at 305", Aref_en, tk);
    else n_pass++;
    Aref_done = 1'b1;
    tick();
    Aref_done = 1'b0;
  endtask

  task automatic test_ref_err();
    run_to(401);
    tick();
    n_chk++;
    if (Aref_en !== 1'b1) $display("FAIL aref_402: got %b want 1", Aref_en);
    else n_pass++;
    run_to(600);
    n_chk++;
    if (Ref_err !== 1'b0) $display("FAIL ref_err_early: got %b want 0", Ref_err);
    else n_pass++;
    tick();
    n_chk++;
    if (Ref_err !== 1'b1) $display("FAIL ref_err_set: got %b want 1", Ref_err);
    else n_pass++;
    run_to(651);
    Aref_done = 1'b1;
    tick();
    Aref_done = 1'b0;
    tick();
    n_chk++;
    if (Aref_en !== 1'b1 || Ref_err !== 1'b1)
      $display("FAIL ref_err_sticky: got aref=%b err=%b want 1/1", Aref_en, Ref_err);
    else n_pass++;
    Aref_done = 1'b1;
    tick();
    Aref_done = 1'b0;
  endtask

  task automatic test_init_drop();
    int at;
    run_to(659);
    Wr_req = 1'b1;
    tick();
    Wr_req = 1'b0;
    n_chk++;
    if (Wr_en !== 1'b1) $display("FAIL wr_before_drop: got %b want 1", Wr_en);
    else n_pass++;
    run_to(663);
    Init_done = 1'b0;
    tick();
    n_chk++;
    if ({Aref_en, Wr_en, Rd_en, Cmd_sel, Busy, Ref_err} !== 7'b0000001)
      $display("FAIL init_drop: got %b want 0000001", {Aref_en, Wr_en, Rd_en, Cmd_sel, Busy, Ref_err});
    else n_pass++;
    run_to(670);
    Init_done = 1'b1;
    tick();
    at = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (Aref_en) begin at = tk; break; end
    end
    // Timer restarted from 0 at the new IDLE entry (tk=671).
    n_chk++;
    if (at !== 772) $display("FAIL reinit_timer: got tk=%0d want 772", at);
    else n_pass++;
    Aref_done = 1'b1;
    tick();
    Aref_done = 1'b0;
  endtask

  task automatic test_rst_mid_read();
    Rd_req = 1'b1;
    tick();
    Rd_req = 1'b0;
    tick();
    n_chk++;
    if (Cmd_sel !== 2'd3) $display("FAIL mid_read: got sel=%0d want 3", Cmd_sel);
    else n_pass++;
    #2;
    Rst = 1'b1;
    #1;
    n_chk++;
    if ({Aref_en, Wr_en, Rd_en, Cmd_sel, Busy, Ref_err} !== 7'd0)
      $display("FAIL async_rst: got %b want 0000000", {Aref_en, Wr_en, Rd_en, Cmd_sel, Busy, Ref_err});
    else n_pass++;
    tick();
    Rst = 1'b0;
    tick();
    Wr_req = 1'b1; Rd_req = 1'b1;
    tick();
    n_chk++;
    if (Wr_en !== 1'b1 || Rd_en !== 1'b0)
      $display("FAIL tie_after_reset: got wr=%b rd=%b want 1/0", Wr_en, Rd_en);
    else n_pass++;
    Wr_req = 1'b0;
    Wr_done = 1'b1;
    tick();
    Wr_done = 1'b0;
    tick();
    n_chk++;
    if (Rd_en !== 1'b1 || Cmd_sel !== 2'd3)
      $display("FAIL rd_after_wr: got rd=%b sel=%0d want 1/3", Rd_en, Cmd_sel);
    else n_pass++;
    Rd_req = 1'b0;
    Rd_done = 1'b1;
    tick();
    Rd_done = 1'b0;
    n_chk++;
    if (Cmd_sel !== 2'd0 || Busy !== 1'b0)
      $display("FAIL final_idle: got sel=%0d busy=%b want 0/0", Cmd_sel, Busy);
    else n_pass++;
  endtask

  task automatic test_no_stray();
    n_chk++;
    if (stray !== 0) $display("FAIL stray_grants: got %0d want 0", stray);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_refresh_after_read();
    test_wrap_vs_grant();
    test_ref_err();
    test_init_drop();
    test_rst_mid_read();
    test_no_stray();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
